// File: rtl/truth_sweep_ctrl.sv
// Truth-table sweep controller: walks the operands {a,b,c} through all eight
// vectors, holds each vector for HOLD cycles so the function under test can
// settle, then captures y_in on the last hold cycle of each vector. At the end
// of the sweep the captured table is compared against a golden table.
module truth_sweep_ctrl #(
    parameter int HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [7:0] mismatch
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST_HOLD = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      index;
    logic [CW-1:0]   hold_cnt;
    logic [7:0]      cap_table;
    logic [7:0]      cap_next;
    logic            accept;
    logic            last_hold;

    // Qualify the two events that drive everything else: an accepted start
    // (abort has priority) and the settled sample point of the current vector.
    always_comb begin
        accept    = 1'b0;
        last_hold = 1'b0;
        accept    = (state == IDLE) && start && !abort;
        last_hold = (state == APPLY) && !abort && (hold_cnt == LAST_HOLD);
    end

    // Next-state logic; FINISH always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_hold && (index == 3'd7)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand drive and status flags, decoded from state so reset clears them at once.
    always_comb begin
        a    = 1'b0;
        b    = 1'b0;
        c    = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        if (state == APPLY) begin
            {a, b, c} = index;
            busy      = 1'b1;
        end
        done = (state == FINISH);
    end

    // Working table with the current vector's bit replaced by the live result.
    always_comb begin
        cap_next        = cap_table;
        cap_next[index] = y_in;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sweep datapath: vector index, hold counter, capture and registered verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index     <= 3'd0;
            hold_cnt  <= '0;
            cap_table <= 8'h00;
            table_out <= 8'h00;
            pass      <= 1'b0;
            mismatch  <= 8'h00;
        end else if (accept) begin
            index     <= 3'd0;
            hold_cnt  <= '0;
            cap_table <= 8'h00;
            table_out <= 8'h00;
            pass      <= 1'b0;
            mismatch  <= 8'h00;
        end else if (state == APPLY) begin
            if (abort) begin
                index     <= 3'd0;
                hold_cnt  <= '0;
                cap_table <= 8'h00;
                table_out <= 8'h00;
                pass      <= 1'b0;
                mismatch  <= 8'h00;
            end else if (last_hold) begin
                cap_table <= cap_next;
                hold_cnt  <= '0;
                if (index == 3'd7) begin
                    index     <= 3'd0;
                    table_out <= cap_next;
                    pass      <= (cap_next == expected);
                    mismatch  <= cap_next ^ expected;
                end else begin
                    index <= index + 3'd1;
                end
            end else begin
                hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Directed self-checking bench for truth_sweep_ctrl (HOLD=3 and HOLD=1 instances).
module tb_truth_sweep_ctrl;

    localparam int H0 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [7:0] expected;
    logic       y_in;
    logic       a, b, c, busy, done, pass;
    logic [7:0] table_out, mismatch;

    logic       start1;
    logic       y_in1;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [7:0] table_out1, mismatch1;

    logic       glitch;
    int         phase;
    int         n_cmp = 0;
    int         n_err = 0;

    truth_sweep_ctrl #(.HOLD(H0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
        .y_in(y_in), .a(a), .b(b), .c(c), .busy(busy), .done(done),
        .table_out(table_out), .pass(pass), .mismatch(mismatch)
    );

    truth_sweep_ctrl #(.HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .expected(8'h5F),
        .y_in(y_in1), .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
        .table_out(table_out1), .pass(pass1), .mismatch(mismatch1)
    );

    always #5 clk = ~clk;

    // Function under test: y = NOT(a AND c), optionally wrong before the last hold cycle.
    always @(posedge clk) begin
        if (busy) phase <= (phase == H0 - 1) ? 0 : phase + 1;
        else      phase <= 0;
    end
    assign y_in  = (glitch && (phase != H0 - 1)) ? (a & c) : ~(a & c);
    assign y_in1 = ~(a1 & c1);

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] exp_val);
        n_cmp++;
        assert (observed === exp_val) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, exp_val);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic ab);
        start = s;
        abort = ab;
    endtask

    task automatic checkIdleClear(input string tag);
        checkOutput({tag, "_abc"}, 32'({a, b, c}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_table"}, 32'(table_out), 32'h00);
        checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
        checkOutput({tag, "_mm"}, 32'(mismatch), 32'h00);
    endtask

    // Full sweep on the HOLD=3 instance with per-cycle operand checks.
    task automatic runSweep(input string tag, input logic [7:0] gold,
                            input logic [7:0] want_tab, input logic want_pass,
                            input logic [7:0] want_mm);
        expected = gold;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < H0; h++) begin
                checkOutput({tag, "_abc"}, 32'({a, b, c}), 32'(v));
                checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
                checkOutput({tag, "_nodone"}, 32'(done), 32'd0);
                @(negedge clk);
            end
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busyfin"}, 32'(busy), 32'd0);
        checkOutput({tag, "_abcfin"}, 32'({a, b, c}), 32'd0);
        checkOutput({tag, "_table"}, 32'(table_out), 32'(want_tab));
        checkOutput({tag, "_pass"}, 32'(pass), 32'(want_pass));
        checkOutput({tag, "_mm"}, 32'(mismatch), 32'(want_mm));
        @(negedge clk);
        checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_held"}, 32'(table_out), 32'(want_tab));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        start1   = 1'b0;
        glitch   = 1'b0;
        expected = 8'h5F;
        #3;
        checkIdleClear("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdleClear("post_reset");

        // Matching golden table.
        runSweep("sweep_pass", 8'h5F, 8'h5F, 1'b1, 8'h00);

        // Changing expected after completion must not alter held verdict.
        expected = 8'hFF;
        @(negedge clk);
        checkOutput("held_pass", 32'(pass), 32'd1);
        checkOutput("held_mm", 32'(mismatch), 32'h00);

        // Wrong golden table.
        runSweep("sweep_fail", 8'hFF, 8'h5F, 1'b0, 8'hA0);

        // Unsettled result in early hold cycles is ignored.
        glitch = 1'b1;
        runSweep("settle", 8'h5F, 8'h5F, 1'b1, 8'h00);
        glitch = 1'b0;

        // Start re-pulsed at vector 3 is ignored; one done at the original time.
        expected = 8'h5F;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("restart_vec3", 32'({a, b, c}), 32'd3);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        repeat (12) @(negedge clk);
        checkOutput("restart_early", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("restart_done", 32'(done), 32'd1);
        checkOutput("restart_table", 32'(table_out), 32'h5F);
        @(negedge clk);
        checkOutput("restart_notqueued", 32'(busy), 32'd0);
        checkOutput("restart_single", 32'(done), 32'd0);

        // Abort at vector 3.
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("abort_vec3", 32'({a, b, c}), 32'd3);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkIdleClear("abort");
        for (int i = 0; i < 20; i++) begin
            checkOutput("abort_nodone", 32'(done), 32'd0);
            @(negedge clk);
        end

        // Abort together with start in IDLE wins.
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_prio_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("abort_prio_busy2", 32'(busy), 32'd0);

        // Asynchronous reset at vector 5, between edges.
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (15) @(negedge clk);
        checkOutput("rst_vec5", 32'({a, b, c}), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        checkIdleClear("rst_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            checkOutput("rst_nodone", 32'(done), 32'd0);
            @(negedge clk);
        end
        runSweep("after_rst", 8'h5F, 8'h5F, 1'b1, 8'h00);

        // HOLD=1 instance: a new vector every cycle, done 9 cycles after start.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int v = 0; v < 8; v++) begin
            checkOutput("h1_abc", 32'({a1, b1, c1}), 32'(v));
            checkOutput("h1_busy", 32'(busy1), 32'd1);
            @(negedge clk);
        end
        checkOutput("h1_done", 32'(done1), 32'd1);
        checkOutput("h1_table", 32'(table_out1), 32'h5F);
        checkOutput("h1_pass", 32'(pass1), 32'd1);
        checkOutput("h1_mm", 32'(mismatch1), 32'h00);
        @(negedge clk);
        checkOutput("h1_donepulse", 32'(done1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/truth_sweep_ctrl.md
TRUTH_SWEEP_CTRL -- requirements
Module: truth_sweep_ctrl

Interface
REQ-001 SHALL have parameter HOLD, default 3, giving clock cycles each input vector is held (legal range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a full 8-vector sweep; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a running sweep.
REQ-006 SHALL have port expected  input  8  golden truth table; bit i = expected y for vector i = {a,b,c}.
REQ-007 SHALL have port y_in  input  1  result returned by the combinational function under test.
REQ-008 SHALL have ports a, b, c  output  1 each  operand drives to the function under test; vector index = {a,b,c}.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse on sweep completion.
REQ-011 SHALL have port table_out  output  8  captured truth table; bit i = y_in sampled for vector i.
REQ-012 SHALL have port pass  output  1  table_out == expected; valid from done pulse onward.
REQ-013 SHALL have port mismatch  output  8  table_out XOR expected; valid from done pulse onward.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, FINISH.
REQ-015 IDLE: start=1 at an edge -> APPLY, vector index 0, hold counter 0, table cleared to 0x00; start=0 -> stay.
REQ-016 APPLY: {a,b,c} SHALL equal the current index (0..7); busy=1.
REQ-017 APPLY: hold counter SHALL count 0..HOLD-1; y_in SHALL be sampled into table bit[index] only at the edge where counter == HOLD-1 (earlier cycles ignored, settling time).
REQ-018 At that edge: index < 7 -> index+1, counter 0; index == 7 -> FINISH, index wraps to 0.
REQ-019 FINISH: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
REQ-020 With start at edge E0, busy SHALL be high in cycles E0+1 .. E0+8*HOLD, done high in cycle E0+8*HOLD+1.
REQ-021 pass, mismatch, table_out SHALL be registered, updated at the edge entering FINISH, held until the next accepted start.
REQ-022 start asserted during APPLY or FINISH SHALL be ignored (not queued).
REQ-023 abort=1 in APPLY SHALL return to IDLE at that edge: busy=0 next cycle, no done pulse, {a,b,c}=000, table_out cleared to 0x00, pass=0, mismatch=0x00.
REQ-024 abort=1 in IDLE or FINISH SHALL have no effect; abort and start together in IDLE SHALL give abort priority (stay IDLE).
REQ-025 {a,b,c} SHALL be 000 in IDLE and FINISH.
REQ-026 expected SHALL be sampled combinationally when computing pass/mismatch at the FINISH-entry edge; changes afterwards do not alter held results.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, index 0, counter 0, a=b=c=0, busy=0, done=0, table_out=0x00, pass=0, mismatch=0x00, regardless of clock.
REQ-028 rst asserted mid-sweep SHALL discard the sweep; no done pulse after release.
REQ-029 After rst deasserts, the first rising edge with start=1 SHALL begin a sweep normally.

Verification
REQ-030 HOLD=3, y_in = NOT(a AND c), expected=0x5F, start pulse -> vectors 000..111 each 3 cycles, done 25 cycles after start edge, table_out=0x5F, pass=1, mismatch=0x00.
REQ-031 Same stimulus, expected=0xFF -> table_out=0x5F, pass=0, mismatch=0xA0.
REQ-032 y_in forced wrong in first two cycles of each vector, correct on third -> table_out=0x5F (sampling on last hold cycle only).
REQ-033 start re-pulsed while busy at vector 3 -> ignored; single done at original time; abort at vector 3 instead -> busy low next cycle, no done, table_out=0x00.
REQ-034 rst pulsed asynchronously (between edges) at vector 5 -> all outputs 0 immediately; no done; new start afterwards completes normally.
REQ-035 HOLD=1 -> {a,b,c} changes every cycle, done 9 cycles after start edge, table_out=0x5F.
